mixer_duc_mul_sched: RTL and testbench

MIXER_DUC_MUL_SCHED -- requirements
Module: mixer_duc_mul_sched

---
 rtl/mixer_duc_mul_sched_pkg.sv | 22 ++
 rtl/mixer_duc_mul_sched_if.sv | 36 +++
 rtl/mixer_duc_rr_arb.sv | 35 +++
 rtl/mixer_duc_mul_sched.sv | 91 +++++++++
 tb/tb_mixer_duc_mul_sched.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mixer_duc_mul_sched_pkg.sv
// Shared widths and the tag record for the DUC mixer multiplier scheduler.
// Also provides the id-width helper used by the interface, the arbiter and the top.
package mixer_duc_mul_sched_pkg;

  localparam int A_W      = 16;
  localparam int B_W      = 8;
  localparam int P_W      = 24;
  localparam int ID_MAX_W = 8;

  // Ids are stored at the widest supported size; only the low bits are ever set.
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{valid: 1'b0, id: '0};

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mixer_duc_mul_sched_if.sv
// Request, multiplier and result buses of the shared-multiplier scheduler.
// The master modport is the scheduler side; the slave modport is the environment side.
interface mixer_duc_mul_sched_if
  import mixer_duc_mul_sched_pkg::*;
#(
  parameter int NREQ = 4
);

  localparam int ID_W = id_width(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [A_W*NREQ-1:0] req_a;
  logic [B_W*NREQ-1:0] req_b;

  logic                mul_ce;
  logic [A_W-1:0]      mul_din0;
  logic [B_W-1:0]      mul_din1;
  logic [P_W-1:0]      mul_dout;

  logic                res_valid;
  logic                res_ready;
  logic [ID_W-1:0]     res_id;
  logic [P_W-1:0]      res_p;

  modport master (
    input  req_valid, req_a, req_b, mul_dout, res_ready,
    output req_ready, mul_ce, mul_din0, mul_din1, res_valid, res_id, res_p
  );

  modport slave (
    output req_valid, req_a, req_b, mul_dout, res_ready,
    input  req_ready, mul_ce, mul_din0, mul_din1, res_valid, res_id, res_p
  );

endinterface

// File: rtl/mixer_duc_rr_arb.sv
// Round-robin arbiter: searches from ptr upward with wrap and grants the first
// valid requester when en is high. Purely combinational.
module mixer_duc_rr_arb
  import mixer_duc_mul_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  always_comb begin
    // NOTE: every variable is given a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (en && !any && req[k]) begin
        any    = 1'b1;
        idx    = ID_W'(k);
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mixer_duc_mul_sched.sv
// Time-shares one external 16s x 8s multiplier among NREQ requesters and tags
// each product with its owner so results come back in issue order.
module mixer_duc_mul_sched
  import mixer_duc_mul_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_en,
  output logic                   busy,
  mixer_duc_mul_sched_if.master  bus
);

  localparam int ID_W = id_width(NREQ);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic            mul_ce;
  logic            arb_en;
  tag_t            tags [MUL_LAT];
  tag_t            last_tag;
  logic            unused_id_hi;

  assign last_tag = tags[MUL_LAT-1];

  // A valid result that is not accepted freezes the whole multiplier pipeline.
  assign mul_ce = bus.res_ready | ~last_tag.valid;
  assign arb_en = mul_ce & cfg_en & ~reset;

  mixer_duc_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req (bus.req_valid),
    .en  (arb_en),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign bus.mul_ce    = mul_ce;
  assign bus.req_ready = gnt;
  assign bus.res_valid = last_tag.valid;
  assign bus.res_id    = last_tag.id[ID_W-1:0];
  assign bus.res_p     = bus.mul_dout;

  // Id bits above ID_W are always zero.
  assign unused_id_hi = ^last_tag.id;

  always_comb begin
    bus.mul_din0 = '0;
    bus.mul_din1 = '0;
    if (gnt_any) begin
      bus.mul_din0 = bus.req_a[gnt_idx*A_W +: A_W];
      bus.mul_din1 = bus.req_b[gnt_idx*B_W +: B_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      if (gnt_idx == ID_W'(NREQ - 1)) ptr <= '0;
      else                            ptr <= gnt_idx + 1'b1;
    end
  end

  // NOTE: the tag array is reset because stale valid bits would emit results
  // for discarded products; the multiplier data path itself needs no reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) tags[i] <= TAG_EMPTY;
    end else if (mul_ce) begin
      tags[0] <= '{valid: gnt_any, id: ID_MAX_W'(gnt_idx)};
      for (int i = 1; i < MUL_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) busy = busy | tags[i].valid;
  end

endmodule

// File: tb/tb_mixer_duc_mul_sched.sv
// Directed bench for mixer_duc_mul_sched with a behavioural two-stage multiplier
// as the external product source.
module tb_mixer_duc_mul_sched;

  logic clk;
  logic reset;
  logic cfg_en;
  logic busy;

  int n_chk;
  int n_fail;

  logic signed [15:0] ops_a [4];
  logic signed [7:0]  ops_b [4];
  logic signed [23:0] mul_pipe [2];

  mixer_duc_mul_sched_if #(.NREQ(4)) bus ();

  mixer_duc_mul_sched #(
    .NREQ    (4),
    .MUL_LAT (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cfg_en (cfg_en),
    .busy   (busy),
    .bus    (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External multiplier: two ce-qualified stages.
  always @(posedge clk) begin
    if (bus.mul_ce) begin
      mul_pipe[0] <= 24'($signed(bus.mul_din0)) * 24'($signed(bus.mul_din1));
      mul_pipe[1] <= mul_pipe[0];
    end
  end
  assign bus.mul_dout = mul_pipe[1];

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of sequence");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string name, input logic [23:0] obs, input logic [23:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [23:0] prod(input int i);
    logic signed [23:0] x;
    logic signed [23:0] y;
    x = 24'(ops_a[i]);
    y = 24'(ops_b[i]);
    return x * y;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*16 +: 16] = ops_a[i];
      bus.req_b[i*8 +: 8]   = ops_b[i];
    end
  endtask

  task automatic chk_ready(input logic [3:0] e);
    check("req_ready", 24'(bus.req_ready), 24'(e));
  endtask

  task automatic chk_res(input logic [1:0] id, input logic [23:0] p);
    check("res_valid", 24'(bus.res_valid), 24'd1);
    check("res_id", 24'(bus.res_id), 24'(id));
    check("res_p", bus.res_p, p);
  endtask

  task automatic chk_no_res();
    check("res_valid", 24'(bus.res_valid), 24'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset         = 1'b1;
    cfg_en        = 1'b1;
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1111;
    ops_a[0] = 16'sd10; ops_a[1] = 16'sd20; ops_a[2] = 16'sd30; ops_a[3] = 16'sd40;
    ops_b[0] = 8'sd1;   ops_b[1] = -8'sd2;  ops_b[2] = 8'sd3;   ops_b[3] = -8'sd4;
    drive_ops();

    // Reset state, with every requester asking.
    @(negedge clk); #1;
    chk_ready(4'b0000);
    check("mul_ce", 24'(bus.mul_ce), 24'd1);
    chk_no_res();
    check("busy", 24'(busy), 24'd0);
    check("mul_din0", 24'(bus.mul_din0), 24'd0);
    check("mul_din1", 24'(bus.mul_din1), 24'd0);

    // All four valid: grants rotate 0..3 and ids follow two cycles later.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      reset = 1'b0;
      bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      chk_ready((k < 8) ? 4'(1 << (k % 4)) : 4'b0000);
      if (k >= 2) chk_res(2'((k - 2) % 4), prod((k - 2) % 4));
    end
    @(negedge clk); #1;
    chk_no_res();
    check("busy", 24'(busy), 24'd0);

    // Requester 2 alone: 1000 * -5. Pointer is back at 0.
    ops_a[2] = 16'sd1000;
    ops_b[2] = -8'sd5;
    drive_ops();
    @(negedge clk);
    bus.req_valid = 4'b0100;
    #1;
    chk_ready(4'b0100);
    check("mul_din0", 24'(bus.mul_din0), 24'(16'd1000));
    check("mul_din1", 24'(bus.mul_din1), 24'(8'hFB));
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    chk_ready(4'b0000);
    chk_no_res();
    check("busy", 24'(busy), 24'd1);
    check("mul_din0", 24'(bus.mul_din0), 24'd0);
    @(negedge clk); #1;
    chk_res(2'd2, 24'(-5000));
    @(negedge clk); #1;
    chk_no_res();
    check("busy", 24'(busy), 24'd0);

    // Extreme operands; pointer is at 3, so requester 0 wins, then 1.
    ops_a[0] = 16'sh8000; ops_b[0] = 8'sh80;
    ops_a[1] = 16'sh7FFF; ops_b[1] = 8'sh80;
    drive_ops();
    @(negedge clk);
    bus.req_valid = 4'b0011;
    #1;
    chk_ready(4'b0001);
    @(negedge clk); #1;
    chk_ready(4'b0010);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    chk_res(2'd0, 24'h400000);
    @(negedge clk); #1;
    chk_res(2'd1, 24'(-4194176));
    @(negedge clk); #1;
    chk_no_res();

    // Stall: result for id 2 held for five cycles, requests drop meanwhile.
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    chk_ready(4'b0100);
    @(negedge clk); #1;
    chk_ready(4'b1000);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      bus.res_ready = 1'b0;
      bus.req_valid = (s < 2) ? 4'b1111 : 4'b0000;
      #1;
      chk_res(2'd2, prod(2));
      check("mul_ce", 24'(bus.mul_ce), 24'd0);
      chk_ready(4'b0000);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    #1;
    chk_res(2'd2, prod(2));
    check("mul_ce", 24'(bus.mul_ce), 24'd1);
    @(negedge clk); #1;
    chk_res(2'd3, prod(3));
    @(negedge clk); #1;
    chk_no_res();
    check("busy", 24'(busy), 24'd0);

    // cfg_en dropped after three grants: no more grants, three results drain.
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    chk_ready(4'b0001);
    @(negedge clk); #1;
    chk_ready(4'b0010);
    @(negedge clk); #1;
    chk_ready(4'b0100);
    chk_res(2'd0, prod(0));
    @(negedge clk);
    cfg_en = 1'b0;
    #1;
    chk_ready(4'b0000);
    chk_res(2'd1, prod(1));
    check("busy", 24'(busy), 24'd1);
    @(negedge clk); #1;
    chk_ready(4'b0000);
    chk_res(2'd2, prod(2));
    @(negedge clk); #1;
    chk_ready(4'b0000);
    chk_no_res();
    check("busy", 24'(busy), 24'd0);
    cfg_en = 1'b1;
    bus.req_valid = 4'b0000;

    // Reset with two products in flight; the next grant restarts at index 0.
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    chk_ready(4'b1000);
    @(negedge clk); #1;
    chk_ready(4'b0001);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_no_res();
    check("busy", 24'(busy), 24'd0);
    chk_ready(4'b0000);
    check("mul_ce", 24'(bus.mul_ce), 24'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_ready(4'b0001);
    chk_no_res();
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    chk_no_res();
    check("busy", 24'(busy), 24'd1);
    @(negedge clk); #1;
    chk_res(2'd0, prod(0));
    @(negedge clk); #1;
    chk_no_res();
    check("busy", 24'(busy), 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
